// File: rtl/i2c_match_pkg.sv
// ============================================================================
// i2c_match_pkg : shared constants and FSM state type for the I2C matcher
// Rev 1.0
// ============================================================================
`default_nettype none

package i2c_match_pkg;
  localparam int BYTE_W    = 8;
  localparam int MAX_BYTES = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BITS = 3'd1,
    ST_ACK  = 3'd2,
    ST_HOLD = 3'd3,
    ST_FAIL = 3'd4
  } state_t;
endpackage

`default_nettype wire

// File: rtl/i2c_pattern_matcher_if.sv
// ============================================================================
// i2c_pattern_matcher_if : bus pins, match configuration and status bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface i2c_pattern_matcher_if #(
  parameter int NUM_BYTES = 3
);
  import i2c_match_pkg::*;

  logic                        scl;
  logic                        sda;
  logic                        enable;
  logic [NUM_BYTES*BYTE_W-1:0] pattern;
  logic [NUM_BYTES*BYTE_W-1:0] mask;
  logic                        match;
  logic                        abort;
  logic                        busy;
  logic [2:0]                  byte_idx;

  modport master (
    output scl, sda, enable, pattern, mask,
    input  match, abort, busy, byte_idx
  );

  modport slave (
    input  scl, sda, enable, pattern, mask,
    output match, abort, busy, byte_idx
  );
endinterface

`default_nettype wire

// File: rtl/i2c_edge_sync.sv
// ============================================================================
// i2c_edge_sync : synchronises raw scl/sda and flags scl rise, START and STOP
// Rev 1.0
// ============================================================================
`default_nettype none

module i2c_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic clk,
  input  wire logic reset_n,
  input  wire logic i_scl,
  input  wire logic i_sda,
  output logic      o_scl_rise,
  output logic      o_start_det,
  output logic      o_stop_det,
  output logic      o_sda
);
  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   r_scl_rise;
  logic                   r_start_det;
  logic                   r_stop_det;
  logic                   r_sda;
  logic                   w_scl_s;
  logic                   w_sda_s;

  assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s = r_sda_sync[SYNC_STAGES-1];

  // Detections are registered so a pin edge surfaces SYNC_STAGES+1 clocks later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scl_sync  <= '1;
      r_sda_sync  <= '1;
      r_scl_d     <= 1'b1;
      r_sda_d     <= 1'b1;
      r_scl_rise  <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
      r_sda       <= 1'b1;
    end else begin
      r_scl_sync  <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync  <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_d     <= w_scl_s;
      r_sda_d     <= w_sda_s;
      r_scl_rise  <= w_scl_s & ~r_scl_d;
      r_start_det <= w_scl_s & r_scl_d & r_sda_d & ~w_sda_s;
      r_stop_det  <= w_scl_s & r_scl_d & ~r_sda_d & w_sda_s;
      r_sda       <= w_sda_s;
    end
  end

  assign o_scl_rise  = r_scl_rise;
  assign o_start_det = r_start_det;
  assign o_stop_det  = r_stop_det;
  assign o_sda       = r_sda;
endmodule

`default_nettype wire

// File: rtl/i2c_pattern_matcher.sv
// ============================================================================
// i2c_pattern_matcher : compares a START..STOP I2C frame against pattern/mask
// Optional NACK rejection via `define I2C_MATCH_ACK_CHECK_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module i2c_pattern_matcher
  import i2c_match_pkg::*;
#(
  parameter int NUM_BYTES   = 3,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic           clk,
  input  wire logic           reset_n,
  i2c_pattern_matcher_if.slave bus
);
`ifdef I2C_MATCH_ACK_CHECK_EN
  localparam bit ACK_CHECK = 1'b1;
`else
  localparam bit ACK_CHECK = 1'b0;
`endif
  localparam logic [2:0] LAST_IDX = 3'(NUM_BYTES - 1);

  state_t              r_state, w_state_nxt;
  logic [BYTE_W-1:0]   r_shift, w_shift_nxt;
  logic [2:0]          r_bit_cnt, w_bit_nxt;
  logic [2:0]          r_byte_idx, w_idx_nxt;
  logic                r_match, w_match_nxt;
  logic                r_abort, w_abort_nxt;
  logic                w_scl_rise, w_start, w_stop, w_sda;
  logic [BYTE_W-1:0]   w_shift_in, w_diff;
  logic [BYTE_W-1:0]   w_pat_byte [MAX_BYTES];
  logic [BYTE_W-1:0]   w_msk_byte [MAX_BYTES];

  i2c_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_scl      (bus.scl),
    .i_sda      (bus.sda),
    .o_scl_rise (w_scl_rise),
    .o_start_det(w_start),
    .o_stop_det (w_stop),
    .o_sda      (w_sda)
  );

  for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_bytes
    if (gi < NUM_BYTES) begin : g_used
      assign w_pat_byte[gi] = bus.pattern[(NUM_BYTES-1-gi)*BYTE_W +: BYTE_W];
      assign w_msk_byte[gi] = bus.mask[(NUM_BYTES-1-gi)*BYTE_W +: BYTE_W];
    end else begin : g_unused
      assign w_pat_byte[gi] = '0;
      assign w_msk_byte[gi] = '0;
    end
  end

  assign w_shift_in = {r_shift[BYTE_W-2:0], w_sda};
  assign w_diff     = (w_shift_in ^ w_pat_byte[r_byte_idx]) & w_msk_byte[r_byte_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_byte_idx <= '0;
      r_match    <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_byte_idx <= w_idx_nxt;
      r_match    <= w_match_nxt;
      r_abort    <= w_abort_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit_cnt;
    w_idx_nxt   = r_byte_idx;
    w_match_nxt = 1'b0;
    w_abort_nxt = 1'b0;
    if (!bus.enable) begin
      w_state_nxt = ST_IDLE;
      w_bit_nxt   = '0;
      w_idx_nxt   = '0;
    end else if (w_start) begin
      w_abort_nxt = (r_state == ST_BITS) || (r_state == ST_ACK) || (r_state == ST_HOLD);
      w_state_nxt = ST_BITS;
      w_shift_nxt = '0;
      w_bit_nxt   = '0;
      w_idx_nxt   = '0;
    end else if (w_stop) begin
      w_match_nxt = (r_state == ST_HOLD);
      w_abort_nxt = (r_state == ST_BITS) || (r_state == ST_ACK) || (r_state == ST_FAIL);
      w_state_nxt = ST_IDLE;
    end else if (w_scl_rise) begin
      unique case (r_state)
        ST_BITS: begin
          w_shift_nxt = w_shift_in;
          w_bit_nxt   = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = (w_diff == '0) ? ST_ACK : ST_FAIL;
          end
        end
        ST_ACK: begin
          if (ACK_CHECK && w_sda) begin
            w_state_nxt = ST_FAIL;
          end else if (r_byte_idx == LAST_IDX) begin
            w_state_nxt = ST_HOLD;
          end else begin
            w_idx_nxt   = r_byte_idx + 3'd1;
            w_state_nxt = ST_BITS;
          end
        end
        // The first rise after the last ACK is the clock a STOP or repeated
        // START must ride on; only a second rise proves the frame is too long.
        ST_HOLD: begin
          if (r_bit_cnt == 3'd0) begin
            w_bit_nxt = 3'd1;
          end else begin
            w_state_nxt = ST_FAIL;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.match    = r_match;
  assign bus.abort    = r_abort;
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.byte_idx = r_byte_idx;
endmodule

`default_nettype wire

// File: tb/tb_i2c_pattern_matcher.sv
// ============================================================================
// tb_i2c_pattern_matcher : directed and randomised frames vs. frame-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_i2c_pattern_matcher;
  localparam int NB = 3;
  localparam int SS = 2;
  localparam int HP = 4;
`ifdef I2C_MATCH_ACK_CHECK_EN
  localparam bit ACK_CHK = 1'b1;
`else
  localparam bit ACK_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  i2c_pattern_matcher_if #(.NUM_BYTES(NB)) bus ();

  i2c_pattern_matcher #(.NUM_BYTES(NB), .SYNC_STAGES(SS)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_match  = 0;
  int n_abort  = 0;
  int n_both   = 0;

  logic [NB*8-1:0] pat_v;
  logic [NB*8-1:0] msk_v;
  logic [7:0]      q_data[$];
  bit              q_ack[$];

  always @(negedge clk) begin
    if (bus.match === 1'b1) n_match++;
    if (bus.abort === 1'b1) n_abort++;
    if (bus.match === 1'b1 && bus.abort === 1'b1) n_both++;
  end

  // ---------------- frame-level reference model ----------------
  function automatic logic [7:0] pat_b(input int j);
    return pat_v[(NB-1-j)*8 +: 8];
  endfunction
  function automatic logic [7:0] msk_b(input int j);
    return msk_v[(NB-1-j)*8 +: 8];
  endfunction
  function automatic bit byte_ok(input int j);
    return (((q_data[j] ^ pat_b(j)) & msk_b(j)) == 8'h00) && !(ACK_CHK && q_ack[j]);
  endfunction
  function automatic bit prefix_ok(input int m);
    for (int j = 0; j < m; j++) if (!byte_ok(j)) return 1'b0;
    return 1'b1;
  endfunction
  function automatic bit frame_matches();
    if (q_data.size() != NB) return 1'b0;
    return prefix_ok(NB);
  endfunction
  function automatic logic [7:0] good_byte(input int j);
    return pat_b(j) ^ (8'($urandom) & ~msk_b(j));
  endfunction

  // ---------------- pin-level drivers ----------------
  task automatic hp();
    repeat (HP) @(negedge clk);
  endtask
  task automatic i2c_start();
    bus.sda = 1'b1; bus.scl = 1'b1; hp();
    bus.sda = 1'b0; hp();
    bus.scl = 1'b0; hp();
  endtask
  task automatic i2c_restart();
    bus.sda = 1'b1; hp();
    bus.scl = 1'b1; hp();
    bus.sda = 1'b0; hp();
    bus.scl = 1'b0; hp();
  endtask
  task automatic i2c_stop();
    bus.sda = 1'b0; hp();
    bus.scl = 1'b1; hp();
    bus.sda = 1'b1; hp();
  endtask
  task automatic send_bit(input logic b);
    bus.sda = b; hp();
    bus.scl = 1'b1; hp();
    bus.scl = 1'b0; hp();
  endtask
  task automatic send_byte(input logic [7:0] b, input bit ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(ack);
  endtask
  task automatic send_queue();
    for (int j = 0; j < q_data.size(); j++) send_byte(q_data[j], q_ack[j]);
  endtask
  task automatic settle();
    repeat (12) @(negedge clk);
  endtask
  task automatic load_cfg(input logic [NB*8-1:0] p, input logic [NB*8-1:0] m);
    pat_v = p; msk_v = m;
    bus.pattern = p; bus.mask = m;
  endtask
  task automatic set_frame3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    q_data.delete(); q_ack.delete();
    q_data.push_back(b0); q_data.push_back(b1); q_data.push_back(b2);
    q_ack.push_back(1'b0); q_ack.push_back(1'b0); q_ack.push_back(1'b0);
  endtask

  // Sends q_data as one START..STOP frame and checks the single expected pulse.
  task automatic run_frame(input string name);
    int m0, a0, em, ea;
    m0 = n_match; a0 = n_abort;
    em = frame_matches() ? 1 : 0;
    ea = 1 - em;
    i2c_start(); send_queue(); i2c_stop(); settle();
    n_checks++;
    if (n_match - m0 !== em) begin
      n_fail++; $display("FAIL %s_match: got %0d pulses, expected %0d", name, n_match - m0, em);
    end
    n_checks++;
    if (n_abort - a0 !== ea) begin
      n_fail++; $display("FAIL %s_abort: got %0d pulses, expected %0d", name, n_abort - a0, ea);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.match !== 1'b0) begin n_fail++; $display("FAIL reset_match: got %b expected 0", bus.match); end
    n_checks++; if (bus.abort !== 1'b0) begin n_fail++; $display("FAIL reset_abort: got %b expected 0", bus.abort); end
    n_checks++; if (bus.byte_idx !== 3'd0) begin n_fail++; $display("FAIL reset_byte_idx: got %0d expected 0", bus.byte_idx); end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_latency();
    int m0;
    load_cfg(24'hA0_12_34, 24'hFF_FF_FF);
    set_frame3(8'hA0, 8'h12, 8'h34);
    m0 = n_match;
    @(posedge clk); #1 bus.sda = 1'b0;
    repeat (SS + 1) @(posedge clk);
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL latency_early: busy got %b expected 0", bus.busy); end
    @(posedge clk); #1;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL latency_busy: busy got %b expected 1", bus.busy); end
    @(negedge clk); bus.scl = 1'b0; hp();
    send_queue(); i2c_stop(); settle();
    n_checks++; if (n_match - m0 !== 1) begin n_fail++; $display("FAIL latency_match: got %0d expected 1", n_match - m0); end
  endtask

  task automatic test_exact_match();
    int m0, a0;
    load_cfg(24'hA0_12_34, 24'hFF_FF_FF);
    set_frame3(8'hA0, 8'h12, 8'h34);
    m0 = n_match; a0 = n_abort;
    i2c_start();
    for (int j = 0; j < NB; j++) begin
      send_byte(q_data[j], q_ack[j]);
      n_checks++;
      if (bus.byte_idx !== 3'((j < NB - 1) ? j + 1 : NB - 1)) begin
        n_fail++; $display("FAIL exact_byte_idx%0d: got %0d expected %0d", j, bus.byte_idx, (j < NB - 1) ? j + 1 : NB - 1);
      end
    end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL exact_busy: got %b expected 1", bus.busy); end
    i2c_stop(); settle();
    n_checks++; if (n_match - m0 !== 1) begin n_fail++; $display("FAIL exact_match: got %0d expected 1", n_match - m0); end
    n_checks++; if (n_abort - a0 !== 0) begin n_fail++; $display("FAIL exact_abort: got %0d expected 0", n_abort - a0); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL exact_idle: busy got %b expected 0", bus.busy); end
  endtask

  task automatic test_mask();
    load_cfg(24'hA0_12_34, 24'hFF_F0_FF);
    set_frame3(8'hA0, 8'h1F, 8'h34);
    run_frame("mask_dontcare");
    set_frame3(8'hA0, 8'h22, 8'h34);
    run_frame("mask_mismatch");
  endtask

  task automatic test_nack();
    load_cfg(24'hA0_12_34, 24'hFF_FF_FF);
    set_frame3(8'hA0, 8'h12, 8'h34);
    q_ack[0] = 1'b1;
    run_frame("nack");
  endtask

  task automatic test_repeated_start();
    int m0, a0;
    load_cfg(24'hA0_12_34, 24'hFF_FF_FF);
    m0 = n_match; a0 = n_abort;
    i2c_start();
    send_byte(8'hA0, 1'b0); send_byte(8'h12, 1'b0);
    i2c_restart();
    set_frame3(8'hA0, 8'h12, 8'h34);
    send_queue(); i2c_stop(); settle();
    n_checks++; if (n_abort - a0 !== 1) begin n_fail++; $display("FAIL rstart_abort: got %0d expected 1", n_abort - a0); end
    n_checks++; if (n_match - m0 !== 1) begin n_fail++; $display("FAIL rstart_match: got %0d expected 1", n_match - m0); end
  endtask

  task automatic test_too_long();
    load_cfg(24'hA0_12_34, 24'hFF_FF_FF);
    set_frame3(8'hA0, 8'h12, 8'h34);
    q_data.push_back(8'h56); q_ack.push_back(1'b0);
    run_frame("too_long");
  endtask

  task automatic test_reset_mid_frame();
    int m0, a0;
    load_cfg(24'hA0_12_34, 24'hFF_FF_FF);
    m0 = n_match; a0 = n_abort;
    i2c_start();
    send_byte(8'hA0, 1'b0); send_byte(8'h12, 1'b0);
    for (int i = 7; i >= 4; i--) send_bit(1'(8'h34 >> i));
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.byte_idx !== 3'd0) begin n_fail++; $display("FAIL rstmid_byte_idx: got %0d expected 0", bus.byte_idx); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    hp(); i2c_stop(); settle();
    set_frame3(8'hA0, 8'h12, 8'h34);
    i2c_start(); send_queue(); i2c_stop(); settle();
    n_checks++; if (n_match - m0 !== 1) begin n_fail++; $display("FAIL rstmid_match: got %0d expected 1", n_match - m0); end
    n_checks++; if (n_abort - a0 !== 0) begin n_fail++; $display("FAIL rstmid_abort: got %0d expected 0", n_abort - a0); end
  endtask

  task automatic test_enable_drop();
    int m0, a0;
    load_cfg(24'hA0_12_34, 24'hFF_FF_FF);
    m0 = n_match; a0 = n_abort;
    i2c_start(); send_byte(8'hA0, 1'b0);
    bus.enable = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL enable_busy: got %b expected 0", bus.busy); end
    send_byte(8'h12, 1'b0);
    bus.enable = 1'b1;
    send_byte(8'h34, 1'b0); i2c_stop(); settle();
    n_checks++; if (n_match - m0 !== 0) begin n_fail++; $display("FAIL enable_match: got %0d expected 0", n_match - m0); end
    n_checks++; if (n_abort - a0 !== 0) begin n_fail++; $display("FAIL enable_abort: got %0d expected 0", n_abort - a0); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      int mode, m, len, m0, a0, em, ea;
      load_cfg(NB*8'($urandom), NB*8'($urandom));
      mode = $urandom_range(0, 3);
      len  = (mode == 2) ? $urandom_range(0, NB + 1) : NB;
      q_data.delete(); q_ack.delete();
      for (int j = 0; j < len; j++) begin
        q_data.push_back(good_byte(j));
        q_ack.push_back($urandom_range(0, 3) == 0);
      end
      if (mode == 1 || mode == 3) begin
        int j, k;
        j = $urandom_range(0, NB - 1); k = $urandom_range(0, 7);
        q_data[j] = q_data[j] ^ (8'd1 << k);
      end
      m0 = n_match; a0 = n_abort;
      em = 0; ea = 0;
      i2c_start();
      if (mode == 3) begin
        m = $urandom_range(1, NB - 1);
        ea += prefix_ok(m) ? 1 : 0;
        for (int j = 0; j < m; j++) send_byte(q_data[j], q_ack[j]);
        i2c_restart();
        for (int j = 0; j < NB; j++) begin
          q_data[j] = good_byte(j);
          q_ack[j]  = ($urandom_range(0, 3) == 0);
        end
      end
      if (frame_matches()) em++; else ea++;
      send_queue(); i2c_stop(); settle();
      n_checks++;
      if (n_match - m0 !== em) begin
        n_fail++; $display("FAIL rand%0d_match: mode %0d got %0d expected %0d", it, mode, n_match - m0, em);
      end
      n_checks++;
      if (n_abort - a0 !== ea) begin
        n_fail++; $display("FAIL rand%0d_abort: mode %0d got %0d expected %0d", it, mode, n_abort - a0, ea);
      end
    end
  endtask

  task automatic test_exclusive_pulses();
    n_checks++;
    if (n_both !== 0) begin
      n_fail++; $display("FAIL pulse_overlap: got %0d cycles with both, expected 0", n_both);
    end
  endtask

  initial begin
    bus.scl = 1'b1; bus.sda = 1'b1; bus.enable = 1'b1;
    load_cfg(24'hA0_12_34, 24'hFF_FF_FF);
    test_reset();
    test_latency();
    test_exact_match();
    test_mask();
    test_nack();
    test_repeated_start();
    test_too_long();
    test_reset_mid_frame();
    test_enable_drop();
    test_random();
    test_exclusive_pulses();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
